// File: rtl/pulse_monitor.sv
// Pulse-train monitor: measures high time and period of i_pulse, flags deviations
// from the expected shape, reports lock after enough consecutive good periods.
module pulse_monitor #(
   parameter int EXP_DURATION = 3,
   parameter int EXP_PERIOD   = 7,
   parameter int LOCK_COUNT   = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_pulse,
   input  logic        i_clr,
   output logic [6:0]  o_high_cnt,
   output logic [6:0]  o_period_cnt,
   output logic        o_meas_valid,
   output logic        o_err_duration,
   output logic        o_err_period,
   output logic        o_err_timeout,
   output logic        o_locked,
   output logic [15:0] o_period_total
);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic        r_prev;
   logic [6:0]  r_hi_cnt;
   logic [6:0]  r_per_cnt;
   logic [3:0]  r_good;
   logic [6:0]  w_hi_next;
   logic [6:0]  w_per_next;
   logic [3:0]  w_good_next;
   logic        w_rise;
   logic        w_fall;
   logic        w_measure;
   logic        w_timeout;
   logic        w_load_high;
   logic        w_per_at_limit;
   logic        w_dur_bad;
   logic        w_per_bad;

   assign w_rise         = i_pulse & ~r_prev;
   assign w_fall         = ~i_pulse & r_prev;
   // One more increment would make per_cnt reach 127: that is the timeout point.
   assign w_per_at_limit = (r_per_cnt == 7'd126);
   assign w_dur_bad      = (o_high_cnt != 7'(EXP_DURATION));
   assign w_per_bad      = (r_per_cnt != 7'(EXP_PERIOD));

   always_comb begin
      w_state_next = r_state;
      w_hi_next    = r_hi_cnt;
      w_per_next   = r_per_cnt;
      w_measure    = 1'b0;
      w_timeout    = 1'b0;
      w_load_high  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_rise) begin
               w_hi_next    = 7'd1;
               w_per_next   = 7'd1;
               w_state_next = HIGH;
            end
         end
         HIGH: begin
            if (w_fall) begin
               w_load_high = 1'b1;
            end
            if (w_per_at_limit) begin
               w_timeout = 1'b1;
            end else begin
               w_per_next = r_per_cnt + 7'd1;
               if (i_pulse) begin
                  w_hi_next = r_hi_cnt + 7'd1;
               end else begin
                  w_state_next = LOW;
               end
            end
         end
         LOW: begin
            if (w_rise) begin
               w_measure    = 1'b1;
               w_hi_next    = 7'd1;
               w_per_next   = 7'd1;
               w_state_next = HIGH;
            end else if (w_per_at_limit) begin
               w_timeout = 1'b1;
            end else begin
               w_per_next = r_per_cnt + 7'd1;
            end
         end
         default: w_state_next = IDLE;
      endcase
      if (w_timeout) begin
         w_per_next   = 7'd127;
         w_state_next = IDLE;
      end
   end

   always_comb begin
      w_good_next = r_good;
      if (w_timeout) begin
         w_good_next = 4'd0;
      end else if (w_measure) begin
         if (w_dur_bad || w_per_bad) begin
            w_good_next = 4'd0;
         end else if (r_good < 4'(LOCK_COUNT)) begin
            w_good_next = r_good + 4'd1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= IDLE;
         r_prev    <= 1'b0;
         r_hi_cnt  <= 7'd0;
         r_per_cnt <= 7'd0;
         r_good    <= 4'd0;
      end else begin
         r_state   <= w_state_next;
         r_prev    <= i_pulse;
         r_hi_cnt  <= w_hi_next;
         r_per_cnt <= w_per_next;
         r_good    <= w_good_next;
      end
   end

   // Flag setting wins over a same-cycle clear so no event is ever lost.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_high_cnt     <= 7'd0;
         o_period_cnt   <= 7'd0;
         o_meas_valid   <= 1'b0;
         o_err_duration <= 1'b0;
         o_err_period   <= 1'b0;
         o_err_timeout  <= 1'b0;
         o_locked       <= 1'b0;
         o_period_total <= 16'd0;
      end else begin
         o_meas_valid <= w_measure;
         o_locked     <= (w_good_next == 4'(LOCK_COUNT));
         if (w_load_high) begin
            o_high_cnt <= r_hi_cnt;
         end
         if (w_measure) begin
            o_period_cnt <= r_per_cnt;
         end
         if (w_measure && w_dur_bad) begin
            o_err_duration <= 1'b1;
         end else if (i_clr) begin
            o_err_duration <= 1'b0;
         end
         if (w_measure && w_per_bad) begin
            o_err_period <= 1'b1;
         end else if (i_clr) begin
            o_err_period <= 1'b0;
         end
         if (w_timeout) begin
            o_err_timeout <= 1'b1;
         end else if (i_clr) begin
            o_err_timeout <= 1'b0;
         end
         if (i_clr) begin
            o_period_total <= {15'd0, w_measure};
         end else if (w_measure) begin
            o_period_total <= o_period_total + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_pulse_monitor.sv
// Bench for pulse_monitor: directed scenarios plus random pulse trains, checked
// every cycle against a timestamp-based model of the measured pulse shape.
module tb_pulse_monitor;
   localparam int EXP_D = 3;
   localparam int EXP_P = 7;
   localparam int LOCK  = 4;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_pulse;
   logic        i_clr;
   logic [6:0]  o_high_cnt;
   logic [6:0]  o_period_cnt;
   logic        o_meas_valid;
   logic        o_err_duration;
   logic        o_err_period;
   logic        o_err_timeout;
   logic        o_locked;
   logic [15:0] o_period_total;

   pulse_monitor #(.EXP_DURATION(EXP_D), .EXP_PERIOD(EXP_P), .LOCK_COUNT(LOCK)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pulse(i_pulse), .i_clr(i_clr),
      .o_high_cnt(o_high_cnt), .o_period_cnt(o_period_cnt), .o_meas_valid(o_meas_valid),
      .o_err_duration(o_err_duration), .o_err_period(o_err_period),
      .o_err_timeout(o_err_timeout), .o_locked(o_locked), .o_period_total(o_period_total)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_errors = 0;
   int obs_strobes = 0;

   // Model: a period is described by the sample index of its starting rise and
   // the length of its high phase once the fall has been seen.
   int m_n = 0;
   int m_t_start;
   int m_high_len;
   int m_good;
   bit m_armed;
   bit m_prev;
   int e_high, e_period;
   bit e_valid, e_edur, e_eper, e_eto, e_locked;
   logic [15:0] e_total;

   task automatic model_reset();
      m_armed = 0; m_prev = 0; m_good = 0; m_high_len = -1; m_t_start = 0;
      e_high = 0; e_period = 0; e_valid = 0; e_edur = 0; e_eper = 0; e_eto = 0;
      e_locked = 0; e_total = 16'd0;
   endtask

   task automatic model_step(input bit p, input bit c);
      bit rise, fall, set_dur, set_per, set_to, inc;
      int len;
      rise = p & ~m_prev;
      fall = ~p & m_prev;
      set_dur = 0; set_per = 0; set_to = 0; inc = 0;
      e_valid = 0;
      if (m_armed) begin
         if (rise && m_high_len >= 0) begin
            len      = m_n - m_t_start;
            e_period = len;
            e_valid  = 1;
            inc      = 1;
            set_dur  = (m_high_len != EXP_D);
            set_per  = (len != EXP_P);
            if (set_dur || set_per) m_good = 0;
            else if (m_good < LOCK) m_good++;
            e_locked   = (m_good == LOCK);
            m_t_start  = m_n;
            m_high_len = -1;
         end else begin
            if (fall && m_high_len < 0) begin
               m_high_len = m_n - m_t_start;
               e_high     = m_high_len;
            end
            if (m_n - m_t_start + 1 >= 127) begin
               set_to = 1; m_armed = 0; m_good = 0; e_locked = 0;
            end
         end
      end else if (rise) begin
         m_armed = 1; m_t_start = m_n; m_high_len = -1;
      end
      e_edur = (c ? 1'b0 : e_edur) | set_dur;
      e_eper = (c ? 1'b0 : e_eper) | set_per;
      e_eto  = (c ? 1'b0 : e_eto) | set_to;
      e_total = c ? {15'd0, inc} : e_total + {15'd0, inc};
      m_prev = p;
      m_n++;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s at sample %0d: observed %0d expected %0d", tag, m_n, got, exp);
      end
   endtask

   task automatic check_all();
      check("o_high_cnt", 32'(o_high_cnt), 32'(e_high));
      check("o_period_cnt", 32'(o_period_cnt), 32'(e_period));
      check("o_meas_valid", 32'(o_meas_valid), 32'(e_valid));
      check("o_err_duration", 32'(o_err_duration), 32'(e_edur));
      check("o_err_period", 32'(o_err_period), 32'(e_eper));
      check("o_err_timeout", 32'(o_err_timeout), 32'(e_eto));
      check("o_locked", 32'(o_locked), 32'(e_locked));
      check("o_period_total", 32'(o_period_total), 32'(e_total));
   endtask

   task automatic step(input bit p, input bit c);
      @(negedge i_clk);
      i_pulse = p;
      i_clr   = c;
      @(posedge i_clk);
      model_step(p, c);
      #1;
      if (o_meas_valid === 1'b1) obs_strobes++;
      check_all();
   endtask

   task automatic train(input int h, input int l);
      for (int k = 0; k < h; k++) step(1'b1, 1'b0);
      for (int k = 0; k < l; k++) step(1'b0, 1'b0);
   endtask

   task automatic all_zero_check(input string tag);
      check({tag, "_high"}, 32'(o_high_cnt), 32'd0);
      check({tag, "_period"}, 32'(o_period_cnt), 32'd0);
      check({tag, "_flags"}, 32'({o_meas_valid, o_err_duration, o_err_period, o_err_timeout, o_locked}), 32'd0);
      check({tag, "_total"}, 32'(o_period_total), 32'd0);
   endtask

   initial begin
      int s0, h, l;
      i_rst_n = 1'b0; i_pulse = 1'b0; i_clr = 1'b0;
      model_reset();
      repeat (2) @(posedge i_clk);
      #1;
      all_zero_check("reset");
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // Nominal 3/7 train: five measurements, lock after the fourth.
      obs_strobes = 0;
      for (int k = 0; k < 6; k++) train(3, 4);
      check("nominal_strobes", 32'(obs_strobes), 32'd5);
      check("nominal_locked", 32'(o_locked), 32'd1);
      check("nominal_errs", 32'({o_err_duration, o_err_period, o_err_timeout}), 32'd0);
      $display("nominal train: strobes=%0d locked=%0d high=%0d period=%0d", obs_strobes, o_locked, o_high_cnt, o_period_cnt);

      // One 4/8 period, then relock with flags still set.
      train(4, 4);
      step(1'b1, 1'b0);
      check("bad_unlock", 32'(o_locked), 32'd0);
      check("bad_errdur", 32'(o_err_duration), 32'd1);
      check("bad_errper", 32'(o_err_period), 32'd1);
      train(2, 4);
      for (int k = 0; k < 4; k++) train(3, 4);
      step(1'b1, 1'b0);
      check("relock", 32'(o_locked), 32'd1);
      check("relock_flags", 32'({o_err_duration, o_err_period}), 32'd3);
      $display("mismatch/relock: locked=%0d err_dur=%0d err_per=%0d", o_locked, o_err_duration, o_err_period);

      // Clear coinciding with a mismatching measurement, then a clear alone.
      train(2, 5);
      step(1'b1, 1'b1);
      check("clr_same_errper", 32'(o_err_period), 32'd1);
      check("clr_same_total", 32'(o_period_total), 32'd1);
      step(1'b1, 1'b1);
      check("clr_after_flags", 32'({o_err_duration, o_err_period, o_err_timeout}), 32'd0);
      check("clr_after_total", 32'(o_period_total), 32'd0);
      $display("clear test: err_per=%0d total=%0d", o_err_period, o_period_total);

      // Timeout with input held low after lock.
      step(1'b1, 1'b0);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0);
      for (int k = 0; k < 5; k++) train(3, 4);
      step(1'b1, 1'b0);
      train(2, 0);
      check("pre_to_locked", 32'(o_locked), 32'd1);
      for (int k = 0; k < 130; k++) step(1'b0, 1'b0);
      check("to_flag", 32'(o_err_timeout), 32'd1);
      check("to_unlock", 32'(o_locked), 32'd0);
      s0 = obs_strobes;
      train(3, 4);
      check("to_no_strobe", 32'(obs_strobes - s0), 32'd0);
      $display("low timeout: err_to=%0d locked=%0d", o_err_timeout, o_locked);

      // Input stuck high: timeout, never a strobe.
      for (int k = 0; k < 130; k++) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      s0 = obs_strobes;
      for (int k = 0; k < 126; k++) step(1'b1, 1'b0);
      check("stuck_before", 32'(o_err_timeout), 32'd0);
      for (int k = 0; k < 14; k++) step(1'b1, 1'b0);
      check("stuck_to", 32'(o_err_timeout), 32'd1);
      check("stuck_no_strobe", 32'(obs_strobes - s0), 32'd0);
      $display("stuck high: err_to=%0d strobes=%0d", o_err_timeout, obs_strobes - s0);

      // Asynchronous reset in the middle of a low phase.
      step(1'b0, 1'b0);
      for (int k = 0; k < 3; k++) train(3, 4);
      train(3, 2);
      @(negedge i_clk);
      #2;
      i_rst_n = 1'b0;
      #1;
      model_reset();
      all_zero_check("async_rst");
      @(posedge i_clk);
      #1;
      all_zero_check("async_rst_hold");
      @(negedge i_clk);
      i_rst_n = 1'b1;
      s0 = obs_strobes;
      train(3, 4);
      check("rst_first_rise", 32'(obs_strobes - s0), 32'd0);
      step(1'b1, 1'b0);
      check("rst_second_rise", 32'(obs_strobes - s0), 32'd1);
      check("rst_period", 32'(o_period_cnt), 32'd7);
      train(2, 4);
      $display("async reset: strobes after second rise=%0d", obs_strobes - s0);

      // Random pulse trains with occasional clears and stalls.
      for (int k = 0; k < 80; k++) begin
         h = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : EXP_D;
         l = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : EXP_P - EXP_D;
         if ($urandom_range(0, 19) == 0) l = 128;
         for (int j = 0; j < h; j++) step(1'b1, $urandom_range(0, 15) == 0);
         for (int j = 0; j < l; j++) step(1'b0, $urandom_range(0, 15) == 0);
         $display("random period %0d: high=%0d low=%0d locked=%0d total=%0d", k, h, l, o_locked, o_period_total);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
